// File: rtl/game_status_ctrl.sv
// Game-state sequencer for the HUD: IDLE/CLASSIC/INFINITY/OVER, with HP tracking
// in classic mode and a per-second survival countdown in infinity mode.
module game_status_ctrl #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned HOLDOFF  = 12_500_000,
  parameter int unsigned HP_MAX   = 8,
  parameter int unsigned TIME_MAX = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       start,
  input  logic       hit,
  input  logic       bonus,
  output logic       enable_game_classic,
  output logic       enable_game_infinity,
  output logic [4:0] HP_print,
  output logic [5:0] time_print,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned HP_W   = 5;
  localparam int unsigned TM_W   = 6;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIC,
    S_INFINITY,
    S_OVER
  } state_t;

  state_t              state;
  logic [PRE_W-1:0]    prescaler;
  logic [HOLD_W-1:0]   holdoff;

  // State machine with all HUD outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      prescaler            <= '0;
      holdoff              <= '0;
      enable_game_classic  <= 1'b0;
      enable_game_infinity <= 1'b0;
      HP_print             <= '0;
      time_print           <= '0;
      game_over            <= 1'b0;
      win                  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode == 3'd1) begin
              state               <= S_CLASSIC;
              enable_game_classic <= 1'b1;
              HP_print            <= HP_W'(HP_MAX);
              holdoff             <= '0;
            end else if (mode == 3'd2) begin
              state                <= S_INFINITY;
              enable_game_infinity <= 1'b1;
              time_print           <= TM_W'(TIME_MAX);
              prescaler            <= PRE_W'(TICK_DIV - 1);
            end
          end
        end

        S_CLASSIC: begin
          if (holdoff != '0) begin
            holdoff <= holdoff - HOLD_W'(1);
          end
          // A hit (accepted or not) always discards a coincident bonus
          if (hit) begin
            if (holdoff == '0) begin
              holdoff  <= HOLD_W'(HOLDOFF - 1);
              HP_print <= HP_print - HP_W'(1);
              if (HP_print == HP_W'(1)) begin
                state               <= S_OVER;
                enable_game_classic <= 1'b0;
                game_over           <= 1'b1;
                win                 <= 1'b0;
              end
            end
          end else if (bonus && (HP_print < HP_W'(HP_MAX))) begin
            HP_print <= HP_print + HP_W'(1);
          end
        end

        S_INFINITY: begin
          // A hit takes priority over the final tick and freezes the timer
          if (hit) begin
            state                <= S_OVER;
            enable_game_infinity <= 1'b0;
            game_over            <= 1'b1;
            win                  <= 1'b0;
          end else if (prescaler == '0) begin
            prescaler  <= PRE_W'(TICK_DIV - 1);
            time_print <= time_print - TM_W'(1);
            if (time_print == TM_W'(1)) begin
              state                <= S_OVER;
              enable_game_infinity <= 1'b0;
              game_over            <= 1'b1;
              win                  <= 1'b1;
            end
          end else begin
            prescaler <= prescaler - PRE_W'(1);
          end
        end

        S_OVER: begin
          if (start) begin
            state      <= S_IDLE;
            HP_print   <= '0;
            time_print <= '0;
            win        <= 1'b0;
            game_over  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Bench for game_status_ctrl: event-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_game_status_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned HOLDOFF  = 3;
  localparam int unsigned HP_MAX   = 8;
  localparam int unsigned TIME_MAX = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       bonus = 1'b0;
  logic       enable_game_classic;
  logic       enable_game_infinity;
  logic [4:0] HP_print;
  logic [5:0] time_print;
  logic       game_over;
  logic       win;

  int total = 0;
  int bad   = 0;

  game_status_ctrl #(
    .TICK_DIV (TICK_DIV),
    .HOLDOFF  (HOLDOFF),
    .HP_MAX   (HP_MAX),
    .TIME_MAX (TIME_MAX)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mode                 (mode),
    .start                (start),
    .hit                  (hit),
    .bonus                (bonus),
    .enable_game_classic  (enable_game_classic),
    .enable_game_infinity (enable_game_infinity),
    .HP_print             (HP_print),
    .time_print           (time_print),
    .game_over            (game_over),
    .win                  (win)
  );

  always #5 clk = ~clk;

  // Model phases: 0 menu, 1 classic, 2 infinity, 3 over
  int m_phase   = 0;
  int m_hp      = 0;
  int m_tm      = 0;
  int m_win     = 0;
  int m_valid   = 0;
  int m_cyc     = 0;
  int m_lasthit = 0;
  int m_inf_cyc = 0;

  // Output bundle: {classic, infinity, game_over, win, HP[4:0], time[5:0]}
  function automatic logic [14:0] pack(input logic c, input logic i, input logic g,
                                       input logic w, input logic [4:0] h, input logic [5:0] t);
    return {c, i, g, w, h, t};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cls=%0b inf=%0b ovr=%0b win=%0b hp=%0d t=%0d, want cls=%0b inf=%0b ovr=%0b win=%0b hp=%0d t=%0d",
               name, act[14], act[13], act[12], act[11], act[10:6], act[5:0],
               exp[14], exp[13], exp[12], exp[11], exp[10:6], exp[5:0]);
    end
  endtask

  function automatic logic [14:0] dut_outs();
    return pack(enable_game_classic, enable_game_infinity, game_over, win, HP_print, time_print);
  endfunction

  // Model advance on each edge, then per-cycle comparison once outputs settle
  always @(posedge clk) begin
    m_cyc++;
    if (rst) begin
      m_phase = 0; m_hp = 0; m_tm = 0; m_win = 0; m_valid = 1;
    end else begin
      case (m_phase)
        0: begin
          if (start && mode == 3'd1) begin
            m_phase = 1; m_hp = HP_MAX; m_lasthit = m_cyc - HOLDOFF;
          end else if (start && mode == 3'd2) begin
            m_phase = 2; m_tm = TIME_MAX; m_inf_cyc = 0;
          end
        end
        1: begin
          if (hit) begin
            if (m_cyc - m_lasthit >= HOLDOFF) begin
              m_hp--; m_lasthit = m_cyc;
              if (m_hp == 0) begin m_phase = 3; m_win = 0; end
            end
          end else if (bonus && m_hp < HP_MAX) begin
            m_hp++;
          end
        end
        2: begin
          if (hit) begin
            m_phase = 3; m_win = 0;
          end else begin
            m_inf_cyc++;
            m_tm = TIME_MAX - m_inf_cyc / TICK_DIV;
            if (m_tm == 0) begin m_phase = 3; m_win = 1; end
          end
        end
        default: begin
          if (start) begin m_phase = 0; m_hp = 0; m_tm = 0; m_win = 0; end
        end
      endcase
    end
    #1;
    if (m_valid != 0)
      check("model", dut_outs(),
            pack(m_phase == 1, m_phase == 2, m_phase == 3, m_win != 0, 5'(m_hp), 6'(m_tm)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(1); hit = 1'b0;
  endtask

  task automatic pulse_bonus();
    bonus = 1'b1; step(1); bonus = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    rst = 1'b0;
    check("reset", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    // Classic start
    mode = 3'd1;
    pulse_start();
    mode = 3'd2;
    check("classic_start", dut_outs(), pack(1, 0, 0, 0, 5'd8, 6'd0));

    // Holdoff: hit, hit (ignored), gap, hit
    pulse_hit();
    check("hit1", dut_outs(), pack(1, 0, 0, 0, 5'd7, 6'd0));
    pulse_hit();
    check("hit_holdoff", dut_outs(), pack(1, 0, 0, 0, 5'd7, 6'd0));
    step(1);
    pulse_hit();
    check("hit2", dut_outs(), pack(1, 0, 0, 0, 5'd6, 6'd0));

    // Bonus recovery and saturation; start ignored mid-game
    pulse_bonus();
    pulse_bonus();
    pulse_bonus();
    pulse_start();
    check("bonus_sat", dut_outs(), pack(1, 0, 0, 0, 5'd8, 6'd0));
    hit = 1'b1; bonus = 1'b1; step(1); hit = 1'b0; bonus = 1'b0;
    check("hit_bonus", dut_outs(), pack(1, 0, 0, 0, 5'd7, 6'd0));
    for (int i = 0; i < 7; i++) begin
      step(3);
      pulse_hit();
    end
    check("classic_lost", dut_outs(), pack(0, 0, 1, 0, 5'd0, 6'd0));
    pulse_hit();
    pulse_bonus();
    check("over_hold", dut_outs(), pack(0, 0, 1, 0, 5'd0, 6'd0));
    pulse_start();
    check("over_to_idle", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    // Infinity to timer expiry; mode change and bonus have no effect
    hit = 1'b1; bonus = 1'b1; step(1); hit = 1'b0; bonus = 1'b0;
    mode = 3'd2;
    pulse_start();
    mode = 3'd1;
    check("inf_start", dut_outs(), pack(0, 1, 0, 0, 5'd0, 6'd18));
    step(2);
    pulse_bonus();
    step(1);
    check("inf_tick1", dut_outs(), pack(0, 1, 0, 0, 5'd0, 6'd17));
    step(67);
    check("inf_pre_end", dut_outs(), pack(0, 1, 0, 0, 5'd0, 6'd1));
    step(1);
    check("inf_win", dut_outs(), pack(0, 0, 1, 1, 5'd0, 6'd0));
    pulse_start();
    check("win_to_idle", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    // Infinity killed by a hit at time 10
    mode = 3'd2;
    pulse_start();
    step(32);
    check("inf_t10", dut_outs(), pack(0, 1, 0, 0, 5'd0, 6'd10));
    pulse_hit();
    check("inf_hit", dut_outs(), pack(0, 0, 1, 0, 5'd0, 6'd10));
    step(5);
    check("inf_frozen", dut_outs(), pack(0, 0, 1, 0, 5'd0, 6'd10));
    pulse_start();
    check("inf_to_idle", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    // Hit on the final tick: hit wins
    pulse_start();
    step(71);
    pulse_hit();
    check("final_tick_hit", dut_outs(), pack(0, 0, 1, 0, 5'd0, 6'd1));
    pulse_start();

    // Reset mid-classic at HP 5
    mode = 3'd1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      pulse_hit();
      step(2);
    end
    check("classic_hp5", dut_outs(), pack(1, 0, 0, 0, 5'd5, 6'd0));
    rst = 1'b1; step(1); rst = 1'b0;
    check("mid_reset", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    // Unsupported mode is ignored
    mode = 3'd3;
    pulse_start();
    step(2);
    check("bad_mode", dut_outs(), pack(0, 0, 0, 0, 5'd0, 6'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
